// File: rtl/rt_gpio_debounce.sv
// Multi-channel GPIO input conditioner: per-channel synchronizer, stability
// counter that accepts a new level after DEBOUNCE_CYCLES mismatching cycles, and edge pulses.
module rt_gpio_debounce #(
  parameter int NUM_GPIO        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_GPIO-1:0] gpio_i,
  output logic [NUM_GPIO-1:0] gpio_o,
  output logic [NUM_GPIO-1:0] rise_o,
  output logic [NUM_GPIO-1:0] fall_o,
  output logic                change_o
);

  localparam int              CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_GPIO-1:0] r_sync [SYNC_STAGES];
  logic [NUM_GPIO-1:0] r_stable;
  logic [NUM_GPIO-1:0] r_rise;
  logic [NUM_GPIO-1:0] r_fall;
  logic [CW-1:0]       r_cnt [NUM_GPIO];

  logic [NUM_GPIO-1:0] w_sync;
  logic [NUM_GPIO-1:0] w_mismatch;
  logic [NUM_GPIO-1:0] w_accept;

  assign w_sync     = r_sync[SYNC_STAGES-1];
  assign w_mismatch = w_sync ^ r_stable;

  // A channel accepts its synchronized level on the mismatch cycle that finds the counter saturated.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < NUM_GPIO; i++) begin
      w_accept[i] = w_mismatch[i] && (r_cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= '0;
      end
    end else begin
      r_sync[0] <= gpio_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  // Any matching cycle or an accepted change restarts the count from zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_GPIO; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_GPIO; i++) begin
        if (!w_mismatch[i] || w_accept[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stable <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
    end else begin
      r_stable <= r_stable ^ w_accept;
      r_rise   <= w_accept & w_sync;
      r_fall   <= w_accept & ~w_sync;
    end
  end

  assign gpio_o   = r_stable;
  assign rise_o   = r_rise;
  assign fall_o   = r_fall;
  assign change_o = |{r_rise, r_fall};

endmodule

// File: tb/tb_rt_gpio_debounce.sv
// Bench for rt_gpio_debounce: per-cycle scoreboard against a run-length model,
// a vector table, hand sequences for the multi-cycle corner cases, and random stimulus.
module tb_rt_gpio_debounce;

  localparam int NG  = 4;
  localparam int SS  = 2;
  localparam int DEB = 4;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NG-1:0] gpio_i = '0;
  logic [NG-1:0] gpio_o, rise_o, fall_o;
  logic          change_o;

  always #5 clk = ~clk;

  rt_gpio_debounce #(
    .NUM_GPIO(NG), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .gpio_i(gpio_i),
    .gpio_o(gpio_o), .rise_o(rise_o), .fall_o(fall_o), .change_o(change_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Model counts consecutive mismatches of the delayed input against the accepted level.
  logic [NG-1:0]           m_sync [SS];
  logic [NG-1:0]           m_stable;
  int                      m_run [NG];
  logic [3*NG:0]           exp_q[$];

  task automatic model_clear();
    for (int k = 0; k < SS; k++) m_sync[k] = '0;
    m_stable = '0;
    for (int i = 0; i < NG; i++) m_run[i] = 0;
    exp_q.delete();
  endtask

  task automatic model_edge(input logic [NG-1:0] v);
    logic [NG-1:0] r, f;
    r = '0;
    f = '0;
    for (int i = 0; i < NG; i++) begin
      if (m_sync[SS-1][i] != m_stable[i]) begin
        m_run[i]++;
        if (m_run[i] >= DEB) begin
          m_stable[i] = m_sync[SS-1][i];
          r[i] = m_sync[SS-1][i];
          f[i] = ~m_sync[SS-1][i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    for (int k = SS - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
    m_sync[0] = v;
    exp_q.push_back({m_stable, r, f, |(r | f)});
  endtask

  task automatic check_sb();
    logic [3*NG:0] e;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("sb_outputs", {19'd0, gpio_o, rise_o, fall_o, change_o}, {19'd0, e});
      chk("rise_fall_overlap", {28'd0, rise_o & fall_o}, 32'd0);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [NG-1:0] v);
    @(negedge clk);
    gpio_i = v;
    model_edge(v);
    @(posedge clk);
    #1;
    check_sb();
  endtask

  task automatic check_all_zero(input string name);
    chk(name, {19'd0, gpio_o, rise_o, fall_o, change_o}, 32'd0);
  endtask

  // Asserts reset away from the clock edge, checks outputs clear at once and while held.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_async_clear");
    @(posedge clk);
    #1;
    check_all_zero("reset_held");
    rst_n = 1'b1;
    model_clear();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NG-1:0] in;
    int            hold;
    logic [NG-1:0] exp_o;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int            rises, falls, rise_at;
    logic [NG-1:0] v;

    vecs[0] = '{4'b0001, 6, 4'b0001};
    vecs[1] = '{4'b0011, 5, 4'b0001};
    vecs[2] = '{4'b0011, 1, 4'b0011};
    vecs[3] = '{4'b0000, 3, 4'b0011};
    vecs[4] = '{4'b1111, 3, 4'b0011};
    vecs[5] = '{4'b1111, 5, 4'b1111};
    vecs[6] = '{4'b0101, 6, 4'b0101};

    model_clear();
    #2;
    check_all_zero("reset_initial");
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_initial_clocked");
    rst_n = 1'b1;

    // Table: hold each input pattern, then check the accepted levels.
    for (int t = 0; t < 7; t++) begin
      for (int h = 0; h < vecs[t].hold; h++) step(vecs[t].in);
      chk($sformatf("table_%0d", t), {28'd0, gpio_o}, {28'd0, vecs[t].exp_o});
    end

    // Clean step on channel 0 set up before edge 10 shows after edge 15.
    do_reset();
    for (int i = 0; i < 9; i++) step(4'b0000);
    for (int i = 0; i < 7; i++) begin
      step(4'b0001);
      chk("step_gpio0",  {31'd0, gpio_o[0]}, {31'd0, (i >= 5)});
      chk("step_rise0",  {31'd0, rise_o[0]}, {31'd0, (i == 5)});
      chk("step_change", {31'd0, change_o},  {31'd0, (i == 5)});
    end

    // Short glitch on channel 1 is rejected.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      step((i < 3) ? 4'b0010 : 4'b0000);
      chk("glitch_ch1", {29'd0, gpio_o[1], rise_o[1], fall_o[1]}, 32'd0);
    end

    // Bouncing channel 2 then settling high gives one late rise.
    do_reset();
    rises = 0; falls = 0; rise_at = -1;
    for (int i = 0; i < 12; i++) begin
      step((((i / 2) % 2) == 0) ? 4'b0100 : 4'b0000);
      if (rise_o[2]) rises++;
      if (fall_o[2]) falls++;
    end
    for (int i = 0; i < 12; i++) begin
      step(4'b0100);
      if (rise_o[2]) begin
        rises++;
        rise_at = i;
      end
      if (fall_o[2]) falls++;
    end
    chk("bounce_rise_count", rises, 1);
    chk("bounce_rise_at",    rise_at, 5);
    chk("bounce_fall_count", falls, 0);
    chk("bounce_level",      {31'd0, gpio_o[2]}, 32'd1);

    // Simultaneous rise on channel 1 and fall on channel 3.
    do_reset();
    for (int i = 0; i < 8; i++) step(4'b1000);
    chk("sim_pre_ch3", {31'd0, gpio_o[3]}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      step(4'b0010);
      chk("sim_rise1",  {31'd0, rise_o[1]}, {31'd0, (i == 5)});
      chk("sim_fall3",  {31'd0, fall_o[3]}, {31'd0, (i == 5)});
      chk("sim_change", {31'd0, change_o},  {31'd0, (i == 5)});
    end

    // Reset mid-count discards progress; channel 0 rises 6 edges after release.
    for (int i = 0; i < 4; i++) step(4'b0011);
    chk("midcnt_pre", {28'd0, gpio_o}, 32'b0010);
    do_reset();
    rises = 0;
    for (int i = 0; i < 8; i++) begin
      step(4'b0011);
      chk("post_rst_gpio0", {31'd0, gpio_o[0]}, {31'd0, (i >= 5)});
      chk("post_rst_gpio1", {31'd0, gpio_o[1]}, {31'd0, (i >= 5)});
      if (rise_o[0]) rises++;
    end
    chk("post_rst_rise0_count", rises, 1);

    // Random stimulus with sparse flips so some levels get accepted.
    do_reset();
    v = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NG; i++) begin
        if ($urandom_range(0, 5) == 0) v[i] = ~v[i];
      end
      step(v);
    end

    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
